// File: rtl/packet_dispatcher_if.sv
// Dispatcher bus: host load strobe, consumer requests, memory read port and packet delivery.
// Packets are strobed, so consumers cannot stall them. Requests are level-sensitive and act as the only flow control.
interface packet_dispatcher_if #(
    parameter int NUM_CH    = 4,
    parameter int WORD_W    = 32,
    parameter int PKT_WORDS = 6,
    parameter int NUM_PKTS  = 8,
    parameter int ADDR_W    = 32
);
    localparam int LEFT_W = $clog2(NUM_PKTS + 1);

    logic                        load_done;
    logic [NUM_CH-1:0]           req;
    logic [WORD_W-1:0]           rd_data;
    logic                        rd_en;
    logic [ADDR_W-1:0]           rd_addr;
    logic                        host_sel;
    logic [PKT_WORDS*WORD_W-1:0] pkt_out;
    logic                        pkt_valid;
    logic [NUM_CH-1:0]           grant;
    logic                        empty;
    logic [LEFT_W-1:0]           pkts_left;

    modport master (
        input  load_done, req, rd_data,
        output rd_en, rd_addr, host_sel, pkt_out, pkt_valid, grant, empty, pkts_left
    );

    modport slave (
        output load_done, req, rd_data,
        input  rd_en, rd_addr, host_sel, pkt_out, pkt_valid, grant, empty, pkts_left
    );
endinterface

// File: rtl/packet_dispatcher.sv
// Reads a loaded buffer back one packet at a time and hands each packet to a round-robin-chosen channel.
// pkt_valid comes PKT_WORDS+RD_LAT+1 cycles after req is seen in READY. Packets cannot be stalled; only req gates dispatch.
module packet_dispatcher #(
    parameter int NUM_CH    = 4,
    parameter int WORD_W    = 32,
    parameter int PKT_WORDS = 6,
    parameter int NUM_PKTS  = 8,
    parameter int RD_LAT    = 1,
    parameter int ADDR_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    packet_dispatcher_if.master bus
);
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W     = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;
    localparam int LEFT_W    = $clog2(NUM_PKTS + 1);
    localparam int FETCH_CYC = PKT_WORDS + RD_LAT;
    localparam int CNT_W     = $clog2(FETCH_CYC);
    localparam int BYTES     = WORD_W / 8;

    typedef enum logic [1:0] {IDLE, READY, FETCH, DELIVER} state_t;

    state_t                      state, next_state;
    logic [CH_W-1:0]             rr_ptr, winner, winner_q, idx;
    logic                        found;
    logic [IDX_W-1:0]            pkt_idx;
    logic [CNT_W-1:0]            cnt, slot;
    logic [LEFT_W-1:0]           pkts_left;
    logic [PKT_WORDS*WORD_W-1:0] pkt_out;

    // First requester at or above rr_ptr, wrapping.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state    = state;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        bus.pkt_valid = 1'b0;
        bus.grant     = '0;
        bus.empty     = 1'b0;
        bus.host_sel  = 1'b0;
        unique case (state)
            IDLE: begin
                bus.empty    = 1'b1;
                bus.host_sel = 1'b1;
                if (bus.load_done) next_state = READY;
            end
            READY: begin
                if (|bus.req) next_state = FETCH;
            end
            FETCH: begin
                // Reads occupy the first PKT_WORDS cycles; the tail waits out the read latency.
                if (cnt < CNT_W'(PKT_WORDS)) begin
                    bus.rd_en   = 1'b1;
                    bus.rd_addr = (ADDR_W'(pkt_idx) * ADDR_W'(PKT_WORDS) + ADDR_W'(cnt)) * ADDR_W'(BYTES);
                end
                if (cnt == CNT_W'(FETCH_CYC - 1)) next_state = DELIVER;
            end
            DELIVER: begin
                bus.pkt_valid = 1'b1;
                bus.grant     = NUM_CH'(1) << winner_q;
                next_state    = (pkts_left == LEFT_W'(1)) ? IDLE : READY;
            end
            default: next_state = IDLE;
        endcase
    end

    assign slot = cnt - CNT_W'(RD_LAT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            winner_q  <= '0;
            pkt_idx   <= '0;
            cnt       <= '0;
            pkts_left <= '0;
            pkt_out   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.load_done) begin
                        pkts_left <= LEFT_W'(NUM_PKTS);
                        pkt_idx   <= '0;
                    end
                end
                READY: begin
                    if (|bus.req) begin
                        winner_q <= winner;
                        rr_ptr   <= (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;
                        cnt      <= '0;
                    end
                end
                FETCH: begin
                    cnt <= cnt + 1'b1;
                    if (cnt >= CNT_W'(RD_LAT))
                        pkt_out[int'(slot)*WORD_W +: WORD_W] <= bus.rd_data;
                end
                DELIVER: begin
                    pkts_left <= pkts_left - 1'b1;
                    pkt_idx   <= (pkts_left == LEFT_W'(1)) ? '0 : pkt_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.pkt_out   = pkt_out;
    assign bus.pkts_left = pkts_left;
endmodule

// File: tb/tb_packet_dispatcher.sv
// Randomised scoreboard bench: a default-parameter dispatcher plus a wide, long-latency variant.
module tb_packet_dispatcher;
    localparam int NC0 = 4, WW0 = 32, PW0 = 6, NP0 = 8, RL0 = 1;
    localparam int NC1 = 2, WW1 = 64, PW1 = 4, NP1 = 2, RL1 = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    packet_dispatcher_if #(.NUM_CH(NC0), .WORD_W(WW0), .PKT_WORDS(PW0), .NUM_PKTS(NP0), .ADDR_W(32)) bus0();
    packet_dispatcher_if #(.NUM_CH(NC1), .WORD_W(WW1), .PKT_WORDS(PW1), .NUM_PKTS(NP1), .ADDR_W(32)) bus1();

    packet_dispatcher #(.NUM_CH(NC0), .WORD_W(WW0), .PKT_WORDS(PW0), .NUM_PKTS(NP0), .RD_LAT(RL0), .ADDR_W(32))
        dut0 (.clock(clock), .reset(reset), .bus(bus0));
    packet_dispatcher #(.NUM_CH(NC1), .WORD_W(WW1), .PKT_WORDS(PW1), .NUM_PKTS(NP1), .RD_LAT(RL1), .ADDR_W(32))
        dut1 (.clock(clock), .reset(reset), .bus(bus1));

    // ---------------- memory models ----------------
    logic [31:0] m_seed = '0;
    logic [31:0] pipe0 = '0;
    logic [63:0] p1 [3] = '{64'd0, 64'd0, 64'd0};

    function automatic logic [31:0] data0(input logic [31:0] seed, input logic [31:0] w);
        return seed + 32'h1000 + w;
    endfunction
    function automatic logic [63:0] data1(input logic [31:0] w);
        return {32'hC0DE0000 + w, 32'h5EED0000 ^ (w * 32'h9E3779B1)};
    endfunction

    always @(posedge clock) begin
        pipe0 <= data0(m_seed, bus0.rd_addr >> 2);
        p1[0] <= data1(bus1.rd_addr >> 3);
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end
    assign bus0.rd_data = pipe0;
    assign bus1.rd_data = p1[2];

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // ---------------- reference model (dut0) ----------------
    typedef struct {
        logic [NC0-1:0]      grant;
        logic [PW0*WW0-1:0]  data;
        logic [31:0]         addr0;
        int                  left_after;
    } exp0_t;
    exp0_t sbq0[$];
    int m_rr = 0, m_left = 0, m_idx = 0;

    function automatic int rr_pick(input logic [NC0-1:0] r, input int ptr);
        for (int i = 0; i < NC0; i++)
            if (((r >> ((ptr + i) % NC0)) & 1) != 0) return (ptr + i) % NC0;
        return -1;
    endfunction

    task automatic predict(input logic [NC0-1:0] r, input int n);
        exp0_t e;
        int w;
        for (int j = 0; j < n; j++) begin
            w = rr_pick(r, m_rr);
            e.grant = NC0'(1) << w;
            for (int k = 0; k < PW0; k++)
                e.data[k*WW0 +: WW0] = data0(m_seed, 32'(m_idx * PW0 + k));
            e.addr0 = 32'(m_idx * PW0 * (WW0 / 8));
            m_rr = (w + 1) % NC0;
            m_left--;
            m_idx = (m_left == 0) ? 0 : m_idx + 1;
            e.left_after = m_left;
            sbq0.push_back(e);
        end
    endtask

    // ---------------- monitor (dut0) ----------------
    initial begin
        exp0_t e;
        int addr_n, first_cyc, pend_left;
        logic [31:0] addr_first, addr_prev;
        bit addr_ok, pend;
        addr_n = 0; first_cyc = 0; pend_left = 0;
        addr_first = '0; addr_prev = '0; addr_ok = 1'b1; pend = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                addr_n = 0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    chk("pkts_left_after", bus0.pkts_left, pend_left);
                    if (pend_left == 0) begin
                        chk("empty_after_last", bus0.empty, 1);
                        chk("host_sel_after_last", bus0.host_sel, 1);
                    end
                    pend = 1'b0;
                end
                if (bus0.rd_en) begin
                    chk("rd_en_while_host_sel", bus0.host_sel, 0);
                    if (addr_n == 0) begin
                        first_cyc = cyc;
                        addr_first = bus0.rd_addr;
                        addr_ok = 1'b1;
                    end else if (bus0.rd_addr != addr_prev + 32'd4) begin
                        addr_ok = 1'b0;
                    end
                    addr_prev = bus0.rd_addr;
                    addr_n++;
                end
                if (bus0.pkt_valid) begin
                    if (sbq0.size() == 0) begin
                        flag("unexpected_pkt_valid");
                    end else begin
                        e = sbq0.pop_front();
                        chk("grant", bus0.grant, e.grant);
                        chk("pkt_out", bus0.pkt_out, e.data);
                        chk("first_rd_addr", addr_first, e.addr0);
                        chk("read_count", addr_n, PW0);
                        chk("addr_stride", addr_ok, 1);
                        chk("fetch_latency", cyc - first_cyc, PW0 + RL0);
                        pend = 1'b1;
                        pend_left = e.left_after;
                    end
                    addr_n = 0;
                end
            end
        end
    end

    // ---------------- scoreboard + monitor (dut1) ----------------
    typedef struct {
        logic [NC1-1:0]      grant;
        logic [PW1*WW1-1:0]  data;
        logic [31:0]         addr0;
        int                  t_ready;
    } exp1_t;
    exp1_t sbq1[$];

    task automatic push1(input logic [NC1-1:0] g, input int idx, input int t);
        exp1_t e;
        e.grant = g;
        for (int k = 0; k < PW1; k++) e.data[k*WW1 +: WW1] = data1(32'(idx * PW1 + k));
        e.addr0 = 32'(idx * PW1 * (WW1 / 8));
        e.t_ready = t;
        sbq1.push_back(e);
    endtask

    initial begin
        exp1_t e;
        int addr_n;
        logic [31:0] addr_first, addr_prev;
        bit addr_ok;
        addr_n = 0; addr_first = '0; addr_prev = '0; addr_ok = 1'b1;
        forever begin
            @(negedge clock);
            if (reset) begin
                addr_n = 0;
            end else begin
                if (bus1.rd_en) begin
                    if (addr_n == 0) begin
                        addr_first = bus1.rd_addr;
                        addr_ok = 1'b1;
                    end else if (bus1.rd_addr != addr_prev + 32'd8) begin
                        addr_ok = 1'b0;
                    end
                    addr_prev = bus1.rd_addr;
                    addr_n++;
                end
                if (bus1.pkt_valid) begin
                    if (sbq1.size() == 0) begin
                        flag("wide_unexpected_pkt_valid");
                    end else begin
                        e = sbq1.pop_front();
                        chk("wide_grant", bus1.grant, e.grant);
                        chk("wide_pkt_out", bus1.pkt_out, e.data);
                        chk("wide_first_rd_addr", addr_first, e.addr0);
                        chk("wide_addr_stride", addr_ok, 1);
                        chk("wide_read_count", addr_n, PW1);
                        chk("wide_valid_cycle", cyc - e.t_ready, PW1 + RL1 + 1);
                    end
                    addr_n = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_pkts(input int which, input int n);
        int seen = 0;
        for (int c = 0; c < 40 * n + 40; c++) begin
            @(negedge clock);
            if ((which == 0 && bus0.pkt_valid) || (which == 1 && bus1.pkt_valid)) seen++;
            if (seen == n) return;
        end
        flag("timeout_waiting_pkt_valid");
    endtask

    task automatic wait_rd();
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (bus0.rd_en) return;
        end
        flag("timeout_waiting_rd_en");
    endtask

    task automatic do_load(input logic [31:0] seed);
        @(negedge clock);
        m_seed = seed;
        m_left = NP0;
        m_idx = 0;
        bus0.load_done = 1'b1;
        @(negedge clock);
        bus0.load_done = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, bus0.rd_en, 0);
        chk({tag, "_rd_addr"}, bus0.rd_addr, 0);
        chk({tag, "_pkt_out"}, bus0.pkt_out, 0);
        chk({tag, "_pkt_valid"}, bus0.pkt_valid, 0);
        chk({tag, "_grant"}, bus0.grant, 0);
        chk({tag, "_pkts_left"}, bus0.pkts_left, 0);
        chk({tag, "_empty"}, bus0.empty, 1);
        chk({tag, "_host_sel"}, bus0.host_sel, 1);
    endtask

    task automatic random_until_empty();
        logic [NC0-1:0] pat;
        int n;
        while (m_left > 0) begin
            pat = NC0'($urandom_range(1, (1 << NC0) - 1));
            n = $urandom_range(1, (m_left < 3) ? m_left : 3);
            predict(pat, n);
            bus0.req = pat;
            wait_pkts(0, n);
            bus0.req = '0;
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
    endtask

    initial begin
        int rd_cnt;
        bus0.load_done = 1'b0; bus0.req = '0;
        bus1.load_done = 1'b0; bus1.req = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;

        // load_done and req together: READY first, reads start one cycle later
        @(negedge clock);
        m_seed = '0; m_left = NP0; m_idx = 0;
        predict(4'b0001, 2);
        bus0.load_done = 1'b1;
        bus0.req = 4'b0001;
        @(negedge clock);
        bus0.load_done = 1'b0;
        chk("ready_rd_en", bus0.rd_en, 0);
        chk("ready_host_sel", bus0.host_sel, 0);
        chk("ready_empty", bus0.empty, 0);
        chk("ready_pkts_left", bus0.pkts_left, NP0);
        @(negedge clock);
        chk("first_rd_en", bus0.rd_en, 1);
        chk("first_rd_addr_zero", bus0.rd_addr, 0);
        wait_pkts(0, 1);
        wait_pkts(0, 1);
        bus0.req = '0;

        // stray load_done and a dropped request during FETCH
        predict(4'b0100, 1);
        bus0.req = 4'b0100;
        wait_rd();
        @(negedge clock);
        bus0.load_done = 1'b1;
        @(negedge clock);
        bus0.load_done = 1'b0;
        bus0.req = '0;
        wait_pkts(0, 1);

        random_until_empty();

        bus0.req = '1;
        rd_cnt = 0;
        repeat (20) begin
            @(negedge clock);
            if (bus0.rd_en) rd_cnt++;
        end
        chk("rd_en_after_empty", rd_cnt, 0);
        bus0.req = '0;

        do_load($urandom);
        predict(4'b1010, 2);
        bus0.req = 4'b1010;
        wait_pkts(0, 2);
        bus0.req = '0;

        // reset in the middle of a fetch, after three reads
        bus0.req = 4'b0001;
        wait_rd();
        repeat (2) @(negedge clock);
        #2 reset = 1'b1;
        #1 check_reset_outputs("midfetch_reset");
        bus0.req = '0;
        m_rr = 0; m_left = 0; m_idx = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        do_load('0);
        repeat (5) @(negedge clock);
        predict(4'b1111, 5);
        bus0.req = 4'b1111;
        wait_pkts(0, 5);
        bus0.req = '0;
        predict(4'b0101, 3);
        bus0.req = 4'b0101;
        wait_pkts(0, 3);
        bus0.req = '0;

        do_load($urandom);
        random_until_empty();
        repeat (4) @(negedge clock);
        chk("sb0_drained", sbq0.size(), 0);

        // wide words, four-word packets, three-cycle read latency
        @(negedge clock);
        bus1.load_done = 1'b1;
        @(negedge clock);
        bus1.load_done = 1'b0;
        bus1.req = 2'b10;
        push1(2'b10, 0, cyc);
        wait_pkts(1, 1);
        bus1.req = 2'b11;
        push1(2'b01, 1, cyc + 1);
        wait_pkts(1, 1);
        bus1.req = '0;
        repeat (3) @(negedge clock);
        chk("wide_empty_after_last", bus1.empty, 1);
        chk("sb1_drained", sbq1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/packet_dispatcher.md
# packet_dispatcher

Parametrised packet dispatcher for the trading datapath. Once the host has finished loading a packet buffer into shared memory, this block reads it back one packet at a time and hands each assembled packet to one of NUM_CH downstream consumer modules. Each packet is PKT_WORDS memory words. Consumers are chosen by round-robin arbitration. Memory read latency is configurable, and the block reports remaining-packet count and empty status.

## Interface
Parameters:
- NUM_CH, 4: number of consumer channels (≥1).
- WORD_W, 32: memory word width in bits (multiple of 8).
- PKT_WORDS, 6: words per packet (≥2).
- NUM_PKTS, 8: packets per loaded buffer (≥1).
- RD_LAT, 1: memory read latency in cycles (1..3).
- ADDR_W, 32: byte-address width.

Ports:
- clock, input, 1: clock; all state updates on rising edge.
- reset, input, 1: reset, asynchronous, active-high.
- load_done, input, 1: pulse; the host has finished writing the buffer.
- req, input, NUM_CH: per-channel packet request (level).
- rd_data, input, WORD_W: memory read data.
- rd_en, output, 1: memory read strobe.
- rd_addr, output, ADDR_W: byte address of the read.
- host_sel, output, 1: 1 = host owns the memory port; 0 = dispatcher owns it.
- pkt_out, output, PKT_WORDS*WORD_W: assembled packet; word 0 sits in the LSBs.
- pkt_valid, output, 1: one-cycle strobe; pkt_out is valid.
- grant, output, NUM_CH: one-hot target channel, asserted with pkt_valid.
- empty, output, 1: no packets available.
- pkts_left, output, $clog2(NUM_PKTS+1): undelivered packets in the buffer.

## Operation
- States: IDLE, READY, FETCH, DELIVER.
- IDLE
  - empty=1, host_sel=1, pkts_left=0.
  - On load_done: go to READY; pkt_idx=0; pkts_left=NUM_PKTS.
- READY
  - empty=0, host_sel=0.
  - If any req bit is set: lock the round-robin winner and go to FETCH.
- Round-robin arbitration
  - Winner is the first set req bit at or above rr_ptr, wrapping around.
  - At grant time, rr_ptr becomes (winner+1) mod NUM_CH.
  - rr_ptr resets to 0.
- FETCH
  - Issues PKT_WORDS reads on consecutive cycles: rd_en=1, word index w = pkt_idx*PKT_WORDS + k for k=0..PKT_WORDS-1.
  - rd_addr = w*(WORD_W/8), computed in ADDR_W bits; wrap-around is modulo 2^ADDR_W.
  - Read data is captured into word slot k RD_LAT cycles after its rd_en.
  - After the last capture, go to DELIVER.
- DELIVER (one cycle)
  - pkt_valid=1 and grant = locked winner.
  - pkt_idx increments and pkts_left decrements.
  - If pkts_left becomes 0: go to IDLE and clear pkt_idx. Otherwise go to READY.
- The locked winner is granted even if its req drops during FETCH.
- req changes during FETCH do not alter the winner.
- load_done outside IDLE is ignored.
- load_done and req arriving together in IDLE: go to READY only. Arbitration happens on the next cycle.
- pkt_out holds its value from DELIVER until the next FETCH overwrites slot 0. Consumers must sample it on pkt_valid.
- Reset values (asynchronous, including mid-operation):
  - State = IDLE; rr_ptr = 0; pkt_idx = 0.
  - rd_en=0, rd_addr=0, pkt_out=0, pkt_valid=0, grant=0, pkts_left=0.
  - empty=1, host_sel=1.
  - Any partial packet is discarded; no grant is issued for it.

## Timing
- Cycle t: READY samples req≠0.
- Cycles t+1..t+PKT_WORDS: FETCH, with rd_en=1 for word k in cycle t+1+k.
- The datum for a read issued in cycle c is valid on rd_data in cycle c+RD_LAT and is captured at the end of that cycle.
- pkt_valid and grant are high in cycle t+PKT_WORDS+RD_LAT+1 (t+8 with defaults).
- The next READY is at t+PKT_WORDS+RD_LAT+2. Minimum packet-to-packet spacing is PKT_WORDS+RD_LAT+2 cycles.
- Minimum load_done-to-first-rd_en is 2 cycles.
- host_sel falls in the cycle after load_done is sampled. It rises in the cycle after the final DELIVER.
- rd_en is never high while host_sel=1.

## Test plan
- Single channel, defaults: memory word i = 0x1000+i; load_done, then req[0] held high. Required: pkt_valid at t+8 with grant=0001 and pkt_out word k = 0x1000+k. Second packet holds words 0x1006..0x100B and rd_addr starts at 0x18.
- Round-robin: req=1111 held for 5 packets. Required: grants 0001, 0010, 0100, 1000, 0001. With req=0101 from reset, grants alternate 0001, 0100.
- Exhaustion: NUM_PKTS=8, continuous req. Required: pkts_left counts 8→0; after the 8th pkt_valid, empty=1 and host_sel=1 next cycle; no further rd_en. A second load_done restarts at rd_addr=0.
- Ignored and dropped inputs: load_done pulsed during FETCH leaves pkts_left unchanged. req[2] dropped mid-FETCH is still granted (grant=0100).
- Reset mid-FETCH (after 3 reads): all outputs return to reset values immediately and no pkt_valid follows. After load_done, the first packet again reads word 0.
- RD_LAT=3, PKT_WORDS=4, WORD_W=64: pkt_valid at t+8 and 256-bit pkt_out is correct. rd_addr steps by 8.
